vedic_mult_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational 16x16 Vedic multiplier. It is used in the arithmetic-encoder datapath for range/CDF products. The block splits the operands into half-width Urdhva-Tiryagbhyam partial products over a 3-stage pipeline. It adds a per-transaction signed/unsigned mode and a valid/ready handshake with backpressure.

---
 rtl/vedic_mult_pipe.sv | 91 +++++++++
 tb/tb_vedic_mult_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage signed/unsigned Vedic multiplier with valid/ready whole-pipe stall
module vedic_mul #(
  parameter int W  = 8,
  parameter int BW = 2
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);
  if (W <= BW) begin : g_leaf
    assign o_p = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  end else begin : g_rec
    localparam int H = W / 2;
    logic [W-1:0] w_hh, w_hl, w_lh, w_ll;
    logic [W:0]   w_mid;
    vedic_mul #(.W(H), .BW(BW)) u_hh (.i_a(i_a[W-1:H]), .i_b(i_b[W-1:H]), .o_p(w_hh));
    vedic_mul #(.W(H), .BW(BW)) u_hl (.i_a(i_a[W-1:H]), .i_b(i_b[H-1:0]), .o_p(w_hl));
    vedic_mul #(.W(H), .BW(BW)) u_lh (.i_a(i_a[H-1:0]), .i_b(i_b[W-1:H]), .o_p(w_lh));
    vedic_mul #(.W(H), .BW(BW)) u_ll (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_ll));
    assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
    assign o_p   = {w_hh, w_ll} + ({{(W-1){1'b0}}, w_mid} << H);
  end
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH      = 16,
  parameter int BASE_WIDTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r
);
  localparam int H = WIDTH / 2;
  logic               w_adv, w_acc;
  logic               r_v1, r_sg1, r_v2, r_sg2;
  logic [WIDTH-1:0]   w_ma, w_mb, r_ma, r_mb;
  logic [WIDTH-1:0]   w_hh, w_hl, w_lh, w_ll, r_hh, r_hl, r_lh, r_ll;
  logic [WIDTH:0]     w_mid;
  logic [2*WIDTH-1:0] w_p, w_res;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_acc    = in_valid && w_adv;
  // negating -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
  assign w_ma = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign w_mb = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  vedic_mul #(.W(H), .BW(BASE_WIDTH)) u_hh (.i_a(r_ma[WIDTH-1:H]), .i_b(r_mb[WIDTH-1:H]), .o_p(w_hh));
  vedic_mul #(.W(H), .BW(BASE_WIDTH)) u_hl (.i_a(r_ma[WIDTH-1:H]), .i_b(r_mb[H-1:0]),     .o_p(w_hl));
  vedic_mul #(.W(H), .BW(BASE_WIDTH)) u_lh (.i_a(r_ma[H-1:0]),     .i_b(r_mb[WIDTH-1:H]), .o_p(w_lh));
  vedic_mul #(.W(H), .BW(BASE_WIDTH)) u_ll (.i_a(r_ma[H-1:0]),     .i_b(r_mb[H-1:0]),     .o_p(w_ll));
  assign w_mid = {1'b0, r_hl} + {1'b0, r_lh};
  assign w_p   = {r_hh, r_ll} + ({{(WIDTH-1){1'b0}}, w_mid} << H);
  assign w_res = r_sg2 ? -w_p : w_p;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1      <= 1'b0;
      r_sg1     <= 1'b0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_v2      <= 1'b0;
      r_sg2     <= 1'b0;
      r_hh      <= '0;
      r_hl      <= '0;
      r_lh      <= '0;
      r_ll      <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
    end else if (w_adv) begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_sg1 <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        r_ma  <= w_ma;
        r_mb  <= w_mb;
      end
      r_v2      <= r_v1;
      r_sg2     <= r_sg1;
      r_hh      <= w_hh;
      r_hl      <= w_hl;
      r_lh      <= w_lh;
      r_ll      <= w_ll;
      out_valid <= r_v2;
      if (r_v2) out_r <= w_res;
    end
  end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: scoreboard bench, driver pushes reference products, monitor pops on handoff
module tb_vedic_mult_pipe;
  localparam int W = 16;
  logic             clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
  logic             in_ready, out_valid;
  logic [W-1:0]     in_a = '0, in_b = '0;
  logic [2*W-1:0]   out_r;
  logic [2*W-1:0]   q[$];
  int               errors = 0, checks = 0, rmode = 0, stall_left = 0, lat;
  logic             sp = 1'b0;
  logic [2*W-1:0]   held = '0;
  logic [W-1:0]     ra, rb;
  logic             rs;

  vedic_mult_pipe #(.WIDTH(W), .BASE_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint ea = s ? longint'($signed(a)) : longint'(a);
    longint eb = s ? longint'($signed(b)) : longint'(b);
    longint p  = ea * eb;
    return p[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_op();
    int sel = $urandom_range(0, 7);
    logic [W-1:0] v = W'($urandom);
    if (sel == 0) v = '0;
    else if (sel == 1) v = '1;
    else if (sel == 2) v = {1'b1, {(W-1){1'b0}}};
    else if (sel == 3) v = {1'b0, {(W-1){1'b1}}};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [2*W-1:0] exp);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      #1;
      if (in_ready) begin
        q.push_back(exp);
        @(posedge clk); #1;
        break;
      end
      if (t >= 1000) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // output-side backpressure generator
  initial forever begin
    @(posedge clk); #1;
    if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (rmode == 2 && stall_left > 0 && out_valid) begin out_ready = 1'b0; stall_left--; end
    else out_ready = 1'b1;
  end

  // monitor: handoff happens on the edge after a negedge that shows valid && ready
  initial forever begin
    @(negedge clk);
    if (!reset) sp = 1'b0;
    else begin
      if (sp) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_r), 64'(held));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h with empty scoreboard", out_r);
        end else chk("product", 64'(out_r), 64'(q.pop_front()));
      end
      sp = out_valid && !out_ready;
      held = out_r;
    end
  end

  initial begin
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_r", 64'(out_r), 64'd0);
    @(negedge clk); reset = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk("t1_latency", 64'(lat), 64'd3);
    idle(3);
    send(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
    send(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    send(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
    send(16'h0000, 16'hFFFB, 1'b1, 32'h00000000);
    idle(6);
    stall_left = 4; rmode = 2;
    for (int i = 1; i <= 6; i++) send(16'd100, W'(i), 1'b0, 32'(100 * i));
    idle(12);
    chk("t3_stall_done", 64'(stall_left), 64'd0);
    rmode = 0;
    send(16'd10, 16'd20, 1'b0, 32'd200);
    send(16'hFFFF, 16'd3, 1'b1, 32'hFFFFFFFD);
    send(16'd7, 16'd9, 1'b0, 32'd63);
    #1 reset = 1'b0;
    #1;
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_out_r", 64'(out_r), 64'd0);
    q.delete();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    idle(8);
    rmode = 1;
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        ra = rnd_op(); rb = rnd_op(); rs = 1'($urandom_range(0, 1));
        send(ra, rb, rs, ref_prod(ra, rb, rs));
      end
    end
    rmode = 0;
    for (int t = 0; t < 200 && q.size() > 0; t++) begin @(posedge clk); #1; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still outstanding", q.size());
    end
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
